router_sync_param: RTL and testbench
====================================

# router_sync_param

Parametrised address-latch and channel-supervision block between the router FSM, the NUM_CH output FIFOs and the output ports. It captures the destination address on header detect and steers write enables and the full flag to or from the addressed FIFO. It drives per-channel valid outputs and generates a one-cycle soft reset to any FIFO whose data sits unread for TIMEOUT consecutive cycles. It is a generalised successor of the fixed 3-channel, 30-cycle synchronizer, adding:
- arbitrary channel count
- configurable timeout
- out-of-range address detection

## Interface
Parameters:
- NUM_CH, 3, number of output channels/FIFOs (≥2)
- TIMEOUT, 30, consecutive stalled cycles before soft reset (≥2)
- ADDR_W, clog2(NUM_CH), address width (derived, not overridden)
- TMR_W, clog2(TIMEOUT), timer width (derived)

Ports. One clock; reset is asynchronous and active-high.
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- detect_add  in  1  header detected; latch data_in
- data_in  in  ADDR_W  destination address from header
- write_enb_reg  in  1  FSM request to write current byte
- full  in  NUM_CH  per-FIFO full flags
- empty  in  NUM_CH  per-FIFO empty flags
- read_enb  in  NUM_CH  per-port read enables
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of addressed FIFO
- vld_out  out  NUM_CH  per-port data valid
- soft_reset  out  NUM_CH  per-FIFO one-cycle soft reset
- addr_err  out  1  latched address ≥ NUM_CH

## Operation
Address register:
- On a clock edge with detect_add=1: addr_q<=data_in, addr_ok_q<=(data_in<NUM_CH).
- Otherwise addr_q and addr_ok_q hold.

Combinational outputs:
- write_enb[i] = write_enb_reg & addr_ok_q & (addr_q==i). Otherwise all zero; never more than one bit set.
- fifo_full = addr_ok_q ? full[addr_q] : 0.
- vld_out = ~empty.
- addr_err = ~addr_ok_q.

Per-channel timer (independent for each i). Stall condition: vld_out[i] & ~read_enb[i].
- No stall: cnt<=0, soft_reset[i]<=0.
- Stall and cnt==TIMEOUT-1: soft_reset[i]<=1, cnt<=0.
- Stall otherwise: cnt<=cnt+1, soft_reset[i]<=0.

Timer rules:
- cnt saturates nowhere and wraps only through the TIMEOUT-1 clear above.
- Pulses on different channels may coincide.
- Timer behaviour is independent of address, detect_add and write_enb_reg.

## Timing
Reset values (asynchronous on reset=1, all cleared regardless of clock):
- addr_q=0, addr_ok_q=1, every cnt=0, soft_reset=0.
- Resulting combinational outputs: write_enb=0 unless write_enb_reg, fifo_full=full[0], vld_out=~empty, addr_err=0.

Address latency:
- detect_add sampled at edge k: write_enb, fifo_full and addr_err reflect the new address from edge k on.
- In the cycle where detect_add=1, write_enb uses the previous addr_q.

Soft reset:
- Stall sampled at TIMEOUT consecutive edges gives soft_reset[i] high for exactly one cycle after the last of them.
- If the stall persists, the next pulse comes TIMEOUT edges later.
- A single non-stalled edge (read_enb high or empty high) restarts the count from 0.
- A stall broken on the same edge the count would hit TIMEOUT-1 produces no pulse.

Reset mid-operation:
- Clears any partial count and any pending pulse immediately.
- After release, counting restarts from 0 on the first stalled edge.

## Structure
Shared package router_pkg holds:
- ROUTER_NUM_CH_DFLT=3
- ROUTER_TIMEOUT_DFLT=30
- the clog2 width helper, shared with the FIFO and FSM blocks

Sub-module router_sync_timer:
- One per channel, generated NUM_CH times.
- Parameter TIMEOUT; ports clock, reset, vld, rd, soft_reset.
- Contains its own cnt register.

Top-level contents: address register, one-hot decode, full mux, valid assignment.

## Test plan
- Reset then detect_add with data_in=2, write_enb_reg=1 (NUM_CH=3) -> write_enb=3'b100 from the following edge; fifo_full follows full[2]; addr_err=0.
- NUM_CH=3, data_in=3 latched -> addr_err=1, write_enb=0 with write_enb_reg=1, fifo_full=0 even with full=3'b111.
- empty[0]=0, read_enb[0]=0 held 30 edges (TIMEOUT=30) -> soft_reset[0] pulses one cycle after edge 30; held 60 edges -> second pulse after edge 60.
- Same stall, but read_enb[0]=1 for one cycle at edge 29 -> no pulse at 30; the next pulse comes 30 stalled edges after that read.
- Channels 0 and 2 stalled simultaneously with TIMEOUT=5 and NUM_CH=4 -> soft_reset=4'b0101 for one cycle after edge 5. Then assert reset at stalled edge 3 -> soft_reset stays 0 and the count restarts after release.
- detect_add and write_enb_reg both high in one cycle with old addr 1, new addr 0 -> that cycle write_enb=3'b010; the next cycle write_enb=3'b001.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: default geometry and the width helper used by the
// FIFO, FSM and synchronizer blocks.
package router_pkg;
    localparam int ROUTER_NUM_CH_DFLT  = 3;
    localparam int ROUTER_TIMEOUT_DFLT = 30;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/router_sync_timer.sv
// Per-channel stall supervisor: pulses soft_reset for one cycle after TIMEOUT
// consecutive edges of unread valid data.
module router_sync_timer
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT_DFLT,
    localparam int TMR_W  = clog2(TIMEOUT)
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);
    logic [TMR_W-1:0] cnt;
    logic             stall;

    assign stall = vld & ~rd;

    // The only way out of a running count is a read, an empty FIFO, or the pulse itself.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!stall) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == TMR_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + TMR_W'(1);
            soft_reset <= 1'b0;
        end
    end
endmodule

// File: rtl/router_sync_param.sv
// Router synchronizer: latches the header address, steers write enable / full
// to the addressed FIFO, and supervises every output channel for stalls.
module router_sync_param
    import router_pkg::*;
#(
    parameter int NUM_CH   = ROUTER_NUM_CH_DFLT,
    parameter int TIMEOUT  = ROUTER_TIMEOUT_DFLT,
    localparam int ADDR_W  = clog2(NUM_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);
    logic [ADDR_W-1:0] addr_q;
    logic              addr_ok_q;

    // Reset points at channel 0, which always exists, so the address reads as valid.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            addr_ok_q <= 1'b1;
        end else if (detect_add) begin
            addr_q    <= data_in;
            addr_ok_q <= {1'b0, data_in} < (ADDR_W + 1)'(NUM_CH);
        end
    end

    always_comb begin
        write_enb = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok_q && addr_q == ADDR_W'(i)) begin
                write_enb[i] = write_enb_reg;
                fifo_full    = full[i];
            end
        end
    end

    assign vld_out  = ~empty;
    assign addr_err = ~addr_ok_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        router_sync_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
            .clock      (clock),
            .reset      (reset),
            .vld        (vld_out[i]),
            .rd         (read_enb[i]),
            .soft_reset (soft_reset[i])
        );
    end
endmodule

// File: tb/tb_router_sync_param.sv
// Bench for router_sync_param: a 3-channel/30-cycle and a 4-channel/5-cycle
// instance driven by directed steps and random traffic against a run-length model.
module tb_router_sync_param;
    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Generic per-instance stimulus (index 0: 3ch/30, index 1: 4ch/5)
    logic       det [2];
    int         din [2];
    logic       wer [2];
    logic [7:0] full_v [2];
    logic [7:0] empty_v [2];
    logic [7:0] rd_v [2];

    int nch [2] = '{3, 4};
    int tmo [2] = '{30, 5};

    logic [1:0] a_din, b_din;
    logic [2:0] a_we, a_vld, a_sr;
    logic [3:0] b_we, b_vld, b_sr;
    logic       a_ff, a_err, b_ff, b_err;

    assign a_din = 2'(din[0]);
    assign b_din = 2'(din[1]);

    router_sync_param #(.NUM_CH(3), .TIMEOUT(30)) dut_a (
        .clock(clock), .reset(rst), .detect_add(det[0]), .data_in(a_din),
        .write_enb_reg(wer[0]), .full(full_v[0][2:0]), .empty(empty_v[0][2:0]),
        .read_enb(rd_v[0][2:0]), .write_enb(a_we), .fifo_full(a_ff),
        .vld_out(a_vld), .soft_reset(a_sr), .addr_err(a_err)
    );

    router_sync_param #(.NUM_CH(4), .TIMEOUT(5)) dut_b (
        .clock(clock), .reset(rst), .detect_add(det[1]), .data_in(b_din),
        .write_enb_reg(wer[1]), .full(full_v[1][3:0]), .empty(empty_v[1][3:0]),
        .read_enb(rd_v[1][3:0]), .write_enb(b_we), .fifo_full(b_ff),
        .vld_out(b_vld), .soft_reset(b_sr), .addr_err(b_err)
    );

    // Reference model: latched address plus length of the current stall run per channel
    int         m_addr [2];
    bit         m_ok   [2];
    int         run    [2][4];
    logic [7:0] pend   [2];

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_addr[d] = 0;
            m_ok[d]   = 1'b1;
            pend[d]   = 8'h00;
            for (int i = 0; i < 4; i++) run[d][i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < nch[d]; i++) begin
                if (!empty_v[d][i] && !rd_v[d][i]) begin
                    run[d][i]++;
                    pend[d][i] = (run[d][i] % tmo[d]) == 0;
                end else begin
                    run[d][i]  = 0;
                    pend[d][i] = 1'b0;
                end
            end
            if (det[d]) begin
                m_addr[d] = din[d];
                m_ok[d]   = din[d] < nch[d];
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] mask, e_we;
        logic       e_ff;
        for (int d = 0; d < 2; d++) begin
            mask = 8'((1 << nch[d]) - 1);
            e_we = (wer[d] && m_ok[d]) ? 8'(1 << m_addr[d]) : 8'h00;
            e_ff = m_ok[d] ? full_v[d][m_addr[d]] : 1'b0;
            if (d == 0) begin
                chk("a_write_enb", 32'(a_we), 32'(e_we));
                chk("a_fifo_full", 32'(a_ff), 32'(e_ff));
                chk("a_vld_out", 32'(a_vld), 32'(~empty_v[0] & mask));
                chk("a_addr_err", 32'(a_err), 32'(!m_ok[0]));
                chk("a_soft_reset", 32'(a_sr), 32'(pend[0]));
            end else begin
                chk("b_write_enb", 32'(b_we), 32'(e_we));
                chk("b_fifo_full", 32'(b_ff), 32'(e_ff));
                chk("b_vld_out", 32'(b_vld), 32'(~empty_v[1] & mask));
                chk("b_addr_err", 32'(b_err), 32'(!m_ok[1]));
                chk("b_soft_reset", 32'(b_sr), 32'(pend[1]));
            end
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (!rst) model_edge();
        @(negedge clock);
        #1 compare_all();
    endtask

    task automatic check_now();
        #1 compare_all();
    endtask

    int pc;

    initial begin
        for (int d = 0; d < 2; d++) begin
            det[d] = 0; din[d] = 0; wer[d] = 0;
            full_v[d] = 8'($urandom); empty_v[d] = 8'hff; rd_v[d] = 8'h00;
        end
        model_clear();
        #2 rst = 1'b1;
        model_clear();
        check_now();
        chk("rst_addr_err", 32'(a_err), 32'd0);
        chk("rst_fifo_full", 32'(a_ff), 32'(full_v[0][0]));
        chk("rst_soft_reset", 32'(b_sr), 32'd0);
        cycle();
        cycle();
        rst = 1'b0;

        // Latch address 2 with a write request pending
        det[0] = 1; din[0] = 2; wer[0] = 1;
        cycle();
        det[0] = 0;
        check_now();
        chk("t1_write_enb", 32'(a_we), 32'h4);
        chk("t1_fifo_full", 32'(a_ff), 32'(full_v[0][2]));
        chk("t1_addr_err", 32'(a_err), 32'd0);

        // Out-of-range address
        det[0] = 1; din[0] = 3;
        cycle();
        det[0] = 0; full_v[0] = 8'h07;
        check_now();
        chk("t2_addr_err", 32'(a_err), 32'd1);
        chk("t2_write_enb", 32'(a_we), 32'd0);
        chk("t2_fifo_full", 32'(a_ff), 32'd0);

        // Channel 0 stalled for 60 edges: two pulses
        empty_v[0] = 8'hfe; rd_v[0] = 8'h00; pc = 0;
        for (int k = 0; k < 60; k++) begin
            cycle();
            pc += int'(a_sr[0]);
            if (k == 29) chk("t3_pulse_edge30", 32'(a_sr), 32'h1);
        end
        chk("t3_pulse_count", 32'(pc), 32'd2);

        // A read at stalled edge 29 defers the pulse by a full timeout
        empty_v[0] = 8'hff;
        cycle();
        empty_v[0] = 8'hfe; pc = 0;
        for (int k = 0; k < 28; k++) begin cycle(); pc += int'(a_sr[0]); end
        rd_v[0] = 8'h01;
        cycle(); pc += int'(a_sr[0]);
        rd_v[0] = 8'h00;
        cycle(); pc += int'(a_sr[0]);
        chk("t4_no_pulse", 32'(pc), 32'd0);
        for (int k = 0; k < 29; k++) begin cycle(); pc += int'(a_sr[0]); end
        chk("t4_late_pulse", 32'(pc), 32'd1);
        empty_v[0] = 8'hff;

        // Channels 0 and 2 stalled together on the short-timeout instance
        empty_v[1] = 8'hfa; rd_v[1] = 8'h00;
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_before", 32'(b_sr), 32'd0);
        cycle();
        chk("t5_pulse", 32'(b_sr), 32'h5);
        for (int k = 0; k < 3; k++) cycle();
        rst = 1'b1;
        model_clear();
        check_now();
        chk("t5_reset_clear", 32'(b_sr), 32'd0);
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("t5_restart_before", 32'(b_sr), 32'd0);
        cycle();
        chk("t5_restart_pulse", 32'(b_sr), 32'h5);
        empty_v[1] = 8'hff;

        // Simultaneous detect and write: old address steers this cycle
        det[0] = 1; din[0] = 1; wer[0] = 0;
        cycle();
        det[0] = 1; din[0] = 0; wer[0] = 1;
        check_now();
        chk("t6_old_addr", 32'(a_we), 32'h2);
        cycle();
        det[0] = 0;
        check_now();
        chk("t6_new_addr", 32'(a_we), 32'h1);

        // Random traffic on both instances
        for (int k = 0; k < 600; k++) begin
            for (int d = 0; d < 2; d++) begin
                det[d]     = ($urandom_range(3) == 0);
                din[d]     = $urandom_range(3);
                wer[d]     = 1'($urandom);
                full_v[d]  = 8'($urandom);
                empty_v[d] = 8'($urandom & $urandom);
                rd_v[d]    = 8'($urandom & $urandom & $urandom);
            end
            if ($urandom_range(99) == 0) begin
                rst = 1'b1;
                model_clear();
                check_now();
                cycle();
                rst = 1'b0;
            end
            check_now();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
